// File: rtl/sudoku_cell_mapper_pkg.sv
// sudoku_cell_mapper_pkg: board geometry and digit constants shared by the cell mapper.
package sudoku_cell_mapper_pkg;
  typedef logic [3:0] cell_idx_t;
  localparam cell_idx_t GRID_DIM = 4'd9;
  localparam int BOARD_CELLS = 81;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] EMPTY_DIGIT = 4'd0;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
endpackage

// File: rtl/sudoku_cell_mapper_axis_tracker.sv
// sudoku_axis_tracker: incremental cell index / sub-pixel offset counter for one raster axis.
module sudoku_axis_tracker
  import sudoku_cell_mapper_pkg::*;
#(
  parameter int CELL_SIZE = 14
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_adv,
  input  logic      i_start,
  output cell_idx_t o_idx,
  output logic [3:0] o_sub,
  output logic      o_in
);
  always_ff @(posedge clk)
    if (reset) begin
      o_idx <= '0;
      o_sub <= '0;
      o_in  <= 1'b0;
    end else if (i_adv) begin
      if (i_start) begin
        o_idx <= '0;
        o_sub <= '0;
        o_in  <= 1'b1;
      end else if (o_in) begin
        if (o_sub == 4'(CELL_SIZE - 1)) begin
          o_sub <= '0;
          o_idx <= (o_idx == GRID_DIM - 4'd1) ? '0 : o_idx + 4'd1;
          if (o_idx == GRID_DIM - 4'd1) o_in <= 1'b0;
        end else begin
          o_sub <= o_sub + 4'd1;
        end
      end
    end
endmodule

// File: rtl/sudoku_cell_mapper.sv
// sudoku_cell_mapper: maps the VGA raster onto a 9x9 board cell, owns the digit board, 2-tick pipeline.
// Optional SUDOKU_CURSOR_HIGHLIGHT_EN drives cursor_on from a cell/cursor comparator.
module sudoku_cell_mapper
  import sudoku_cell_mapper_pkg::*;
#(
  parameter logic [9:0] GRID_X0 = 10'd257,
  parameter logic [9:0] GRID_Y0 = 10'd177,
  parameter int CELL_SIZE = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_en,
  input  logic [3:0] wr_row,
  input  logic [3:0] wr_col,
  input  logic [3:0] wr_num,
  input  logic       clear,
  input  logic [3:0] cursor_row,
  input  logic [3:0] cursor_col,
  output logic       num_enable,
  output logic [3:0] num,
  output logic [3:0] posX,
  output logic [3:0] posY,
  output logic [3:0] cell_row,
  output logic [3:0] cell_col,
  output logic       cursor_on,
  output logic       video_on_d,
  output logic       hsync_d,
  output logic       vsync_d
);
  cell_idx_t w_col, w_row;
  logic [3:0] w_sub_x, w_sub_y;
  logic w_in_x, w_in_y, w_in, w_wr_ok;
  logic r_video, r_hs, r_vs;
  logic [DIGIT_W-1:0] r_board [GRID_DIM][GRID_DIM];

  sudoku_axis_tracker #(.CELL_SIZE(CELL_SIZE)) u_x (
    .clk, .reset, .i_adv(pixel_tick), .i_start(pixel_x == GRID_X0),
    .o_idx(w_col), .o_sub(w_sub_x), .o_in(w_in_x)
  );
  // rows advance once per line, on the tick that starts it
  sudoku_axis_tracker #(.CELL_SIZE(CELL_SIZE)) u_y (
    .clk, .reset, .i_adv(pixel_tick && pixel_x == '0), .i_start(pixel_y == GRID_Y0),
    .o_idx(w_row), .o_sub(w_sub_y), .o_in(w_in_y)
  );

  assign w_in = w_in_x && w_in_y && r_video;
  assign w_wr_ok = wr_en && wr_row < GRID_DIM && wr_col < GRID_DIM && wr_num <= MAX_DIGIT;

  always_ff @(posedge clk)
    if (reset || clear) begin
      for (int r = 0; r < int'(GRID_DIM); r++)
        for (int c = 0; c < int'(GRID_DIM); c++)
          r_board[r][c] <= EMPTY_DIGIT;
    end else if (w_wr_ok) begin
      r_board[wr_row][wr_col] <= wr_num;
    end

  always_ff @(posedge clk)
    if (reset) begin
      r_video    <= 1'b0;
      r_hs       <= 1'b0;
      r_vs       <= 1'b0;
      video_on_d <= 1'b0;
      hsync_d    <= 1'b0;
      vsync_d    <= 1'b0;
      num_enable <= 1'b0;
      num        <= EMPTY_DIGIT;
      posX       <= '0;
      posY       <= '0;
      cell_row   <= '0;
      cell_col   <= '0;
    end else if (pixel_tick) begin
      r_video    <= video_on;
      r_hs       <= hsync_in;
      r_vs       <= vsync_in;
      video_on_d <= r_video;
      hsync_d    <= r_hs;
      vsync_d    <= r_vs;
      num_enable <= w_in;
      num        <= w_in ? r_board[w_row][w_col] : EMPTY_DIGIT;
      posX       <= w_in ? w_sub_x : '0;
      posY       <= w_in ? w_sub_y : '0;
      cell_row   <= w_in ? w_row : '0;
      cell_col   <= w_in ? w_col : '0;
    end

`ifdef SUDOKU_CURSOR_HIGHLIGHT_EN
  always_ff @(posedge clk)
    if (reset) cursor_on <= 1'b0;
    else if (pixel_tick) cursor_on <= w_in && w_row == cursor_row && w_col == cursor_col;
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^{cursor_row, cursor_col};
  assign cursor_on = 1'b0;
`endif
endmodule

// File: tb/tb_sudoku_cell_mapper.sv
// tb_sudoku_cell_mapper: raster scans against a coordinate-arithmetic model of the cell mapper.
module tb_sudoku_cell_mapper;
  localparam int X0 = 257, Y0 = 177, CS = 14, SPAN = 126;
`ifdef SUDOKU_CURSOR_HIGHLIGHT_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, pixel_tick, video_on, hsync_in, vsync_in, wr_en, clear;
  logic [9:0] pixel_x, pixel_y;
  logic [3:0] wr_row, wr_col, wr_num, cursor_row, cursor_col;
  logic num_enable, cursor_on, video_on_d, hsync_d, vsync_d;
  logic [3:0] num, posX, posY, cell_row, cell_col;

  always #5 clk = ~clk;

  sudoku_cell_mapper dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_num(wr_num), .clear(clear),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .num_enable(num_enable), .num(num),
    .posX(posX), .posY(posY), .cell_row(cell_row), .cell_col(cell_col), .cursor_on(cursor_on),
    .video_on_d(video_on_d), .hsync_d(hsync_d), .vsync_d(vsync_d)
  );

  int errors = 0, checks = 0;
  int board [9][9];
  bit xs, ys, wr_hook, rst_hook;
  bit s1_in, s1_v, s1_h, s1_vs;
  int s1_r, s1_c, s1_sx, s1_sy;
  logic [24:0] exp_o;
  int hcnt, h0x, h0y, h1x, h1y;
  int en_cnt, cur_cnt;
  logic [3:0] p_num, p_px, p_py, p_r, p_c, p2_num;
  logic p_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (x=%0d y=%0d)", name, act, expv, pixel_x, pixel_y);
    end
  endtask

  task automatic step();
    bit en, inx, iny;
    if (reset) begin
      exp_o = '0;
      {s1_in, s1_v, s1_h, s1_vs} = '0;
      {s1_r, s1_c, s1_sx, s1_sy} = '0;
      xs = 0; ys = 0; hcnt = 0;
      foreach (board[r, c]) board[r][c] = 0;
    end else begin
      if (pixel_tick) begin
        en = s1_in && s1_v;
        exp_o = {en, en ? 4'(board[s1_r][s1_c]) : 4'd0, en ? 4'(s1_sx) : 4'd0, en ? 4'(s1_sy) : 4'd0,
                 en ? 4'(s1_r) : 4'd0, en ? 4'(s1_c) : 4'd0,
                 CUR_EN && en && s1_r == int'(cursor_row) && s1_c == int'(cursor_col), s1_v, s1_h, s1_vs};
        if (int'(pixel_x) == X0) xs = 1;
        if (pixel_x == 0 && int'(pixel_y) == Y0) ys = 1;
        inx = int'(pixel_x) >= X0 && int'(pixel_x) < X0 + SPAN;
        iny = int'(pixel_y) >= Y0 && int'(pixel_y) < Y0 + SPAN;
        s1_in = xs && ys && inx && iny;
        s1_c  = s1_in ? (int'(pixel_x) - X0) / CS : 0;
        s1_r  = s1_in ? (int'(pixel_y) - Y0) / CS : 0;
        s1_sx = s1_in ? (int'(pixel_x) - X0) % CS : 0;
        s1_sy = s1_in ? (int'(pixel_y) - Y0) % CS : 0;
        {s1_v, s1_h, s1_vs} = {video_on, hsync_in, vsync_in};
        h1x = h0x; h1y = h0y; h0x = int'(pixel_x); h0y = int'(pixel_y); hcnt++;
      end
      if (clear) foreach (board[r, c]) board[r][c] = 0;
      else if (wr_en && wr_row < 9 && wr_col < 9 && wr_num < 10) board[wr_row][wr_col] = int'(wr_num);
    end
    @(posedge clk);
    #1;
    check("outputs", 32'({num_enable, num, posX, posY, cell_row, cell_col, cursor_on, video_on_d, hsync_d, vsync_d}), 32'(exp_o));
    if (!reset && pixel_tick && hcnt >= 2) begin
      if (num_enable) en_cnt++;
      if (cursor_on) cur_cnt++;
      if (h1x == 361 && h1y == 242) {p_en, p_num, p_px, p_py, p_r, p_c} = {num_enable, num, posX, posY, cell_row, cell_col};
      if (h1x == 257 && h1y == 177) p2_num = num;
    end
  endtask

  task automatic pix(input int x, input int y, input bit vid);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = vid;
    hsync_in = pixel_x[0]; vsync_in = (y >= 240);
    if (x % 29 == 3) begin pixel_tick = 0; step(); end
    wr_en = wr_hook && x == 362 && y == 242;
    if (wr_en) begin wr_row = 4; wr_col = 7; wr_num = 5; end
    reset = rst_hook && x == 300 && y == 176;
    pixel_tick = 1; step();
    pixel_tick = 0; wr_en = 0; reset = 0;
  endtask

  task automatic scan(input int y_lo, input int y_hi, input int off_y);
    en_cnt = 0; cur_cnt = 0; p_en = 0; p_num = 4'hf; p2_num = 4'hf;
    {p_px, p_py, p_r, p_c} = '1;
    for (int y = y_lo; y <= 305; y++) begin
      pix(0, y, y != off_y);
      if (y <= y_hi) for (int x = 250; x <= 388; x++) pix(x, y, y != off_y);
    end
  endtask

  task automatic wr(input int r, input int c, input int n, input bit cl);
    wr_en = 1; wr_row = 4'(r); wr_col = 4'(c); wr_num = 4'(n); clear = cl;
    step();
    wr_en = 0; clear = 0;
  endtask

  initial begin
    {pixel_tick, video_on, hsync_in, vsync_in, wr_en, clear} = '0;
    {pixel_x, pixel_y, wr_row, wr_col, wr_num} = '0;
    cursor_row = 2; cursor_col = 3;
    {wr_hook, rst_hook} = '0;
    h0x = -1; h0y = -1; h1x = -1; h1y = -1;
    reset = 1;
    repeat (3) step();
    check("reset num_enable", 32'(num_enable), 0);
    check("reset num", 32'(num), 0);
    check("reset video_on_d", 32'(video_on_d), 0);
    reset = 0;

    scan(175, 305, -1);
    check("empty frame enable count", en_cnt, 126 * 126);
    check("cursor count", cur_cnt, CUR_EN ? 196 : 0);

    wr(4, 7, 5, 0);
    scan(175, 245, 200);
    check("probe num", 32'(p_num), 5);
    check("probe posX", 32'(p_px), 6);
    check("probe posY", 32'(p_py), 9);
    check("probe cell_row", 32'(p_r), 4);
    check("probe cell_col", 32'(p_c), 7);
    check("video-off line count", en_cnt, 69 * 126 - 126);

    wr(0, 0, 0, 1);
    wr_hook = 1;
    scan(175, 245, -1);
    wr_hook = 0;
    check("same-cycle write reads old", 32'(p_num), 0);
    check("same-cycle enable", 32'(p_en), 1);

    wr(9, 0, 3, 0);
    wr(0, 0, 12, 0);
    wr(4, 7, 12, 0);
    scan(175, 245, -1);
    check("next frame shows write", 32'(p_num), 5);
    check("invalid writes ignored", 32'(p2_num), 0);

    wr(4, 7, 9, 1);
    scan(175, 245, -1);
    check("clear beats write", 32'(p_num), 0);

    wr(4, 7, 5, 0);
    rst_hook = 1;
    scan(170, 245, -1);
    rst_hook = 0;
    check("reset clears board", 32'(p_num), 0);
    check("post-reset tracking count", en_cnt, 69 * 126);
    check("post-reset probe posX", 32'(p_px), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sudoku_cell_mapper.md
Name: sudoku_cell_mapper

Overview:
- Sits directly upstream of the digit-glyph renderer.
- Converts the VGA controller's raster position into a board cell, a 4-bit local pixel offset inside that cell (posX/posY) and the cell's stored digit; these drive the renderer's enable/num/posX/posY inputs.
- Owns the 9x9 board storage (4 bits per cell) with a single write port driven by game logic.
- Two-stage pipeline; sync and blank signals are delayed to stay aligned with the outputs.

Parameters:
- GRID_X0, 10'd257, screen x of the grid's left edge.
- GRID_Y0, 10'd177, screen y of the grid's top edge.
- CELL_SIZE, 14, cell pitch in pixels; must be ≤ 16 so the local offset fits 4 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pixel_tick  in  1  one-cycle strobe when the raster advances one pixel
- pixel_x  in  10  current raster x
- pixel_y  in  10  current raster y
- video_on  in  1  active-video flag
- hsync_in, vsync_in  in  1 each  raw syncs
- wr_en  in  1  board write strobe
- wr_row, wr_col  in  4 each  target cell, 0..8
- wr_num  in  4  digit 0..9; 0 means empty
- clear  in  1  empty the whole board
- cursor_row, cursor_col  in  4 each  selected cell
- num_enable  out  1  raster inside grid and video on
- num  out  4  digit of the current cell
- posX, posY  out  4 each  local offset, 0..CELL_SIZE-1
- cell_row, cell_col  out  4 each  current cell index
- cursor_on  out  1  current cell is the cursor cell
- video_on_d, hsync_d, vsync_d  out  1 each  inputs delayed 2 ticks

Behaviour:
- Reset is synchronous and active-high. It clears all 81 board cells to 0, all pipeline registers, and all outputs to 0.
- All pipeline stages advance only on pixel_tick; outputs hold between ticks.
- Row tracking runs on ticks where pixel_x == 0:
  - pixel_y == GRID_Y0 → row_idx=0, sub_y=0, in_y=1.
  - Otherwise, if in_y: increment sub_y. When sub_y wraps at CELL_SIZE-1 → sub_y=0 and row_idx+1. When row_idx 8 wraps → in_y=0.
- Column tracking runs on every tick:
  - pixel_x == GRID_X0 → col_idx=0, sub_x=0, in_x=1.
  - Otherwise the same wrap rules apply on the x axis; leaving col 8 clears in_x.
- The trackers are incremental; no divider or multiplier on the raster path.
- Stage 1 (tick N) registers col/row indices, sub offsets, in_x & in_y & video_on, and the syncs.
- Stage 2 (tick N+1) reads board[row*9+col] and registers all outputs.
- Total latency: exactly 2 pixel_ticks from input to every output.
- Outside the grid: num_enable=0, num=0, posX=posY=0, cursor_on=0. Syncs and video_on_d are still delayed.
- Board write:
  - Takes effect on the clock edge with wr_en=1; no tick is required.
  - Ignored if wr_row>8, wr_col>8 or wr_num>9.
  - Same-cell read in the same cycle returns the old value.
- clear:
  - Empties the board in one cycle.
  - clear has priority over wr_en in the same cycle.
- Reset in mid-frame: the trackers re-synchronise at the next pixel_x==0 / pixel_x==GRID_X0 event.
  - Until then, num_enable=0.

Optional Feature:
- Macro: SUDOKU_CURSOR_HIGHLIGHT_EN.
- Defined: cursor_on=1 when the stage-2 cell equals (cursor_row, cursor_col) and num_enable=1.
- Undefined: cursor_on is tied to 0 and the comparator is omitted. The port stays present.

Decomposition:
- Shared package: GRID_DIM=9, BOARD_CELLS=81, DIGIT_W=4, EMPTY_DIGIT=4'd0, MAX_DIGIT=4'd9, and a cell-index typedef (4 bits).
- One sub-module: sudoku_axis_tracker, instantiated twice (x and y) with start-position, advance-strobe and wrap logic.
  - Board storage and the pipeline stay in the top.

Test Plan:
- Reset, then a full frame with an empty board → num_enable=1 only for x∈[257,382], y∈[177,302]; num=0 everywhere.
- Write (row 4, col 7, num 5), then raster (x=257+7*14+6, y=177+4*14+9) → two ticks later: num=5, posX=6, posY=9, cell_row=4, cell_col=7.
- Write (4,7,5) and raster over that cell in the same cycle → the output shows 0; the next frame shows 5.
- Writes with wr_row=9, then wr_num=12 → board unchanged.
- clear and wr_en together → the board reads all 0.
- Cursor (2,3), macro defined → cursor_on=1 for exactly 14×14 pixels per frame.
- Same cursor, macro undefined → cursor_on always 0.
- Assert reset mid-line → all outputs 0 until the next line start; the following line tracks correctly.
